// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU stores queue in a small FIFO and are sent as 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int DepthLog2 = 3
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [3:0]  IO_trans,
    output logic [31:0] Status,
    output logic        FPGA_Sout,
    output logic        TxBusy
);

    localparam int SymbolEdge = ClockFreq / BaudRate;
    localparam int CntW       = (SymbolEdge > 1) ? $clog2(SymbolEdge) : 1;
    localparam int Depth      = 1 << DepthLog2;
    localparam logic [CntW-1:0]    CycLast    = CntW'(SymbolEdge - 1);
    localparam logic [DepthLog2:0] DepthCnt   = (DepthLog2 + 1)'(Depth);
    localparam logic [31:0]        TxDataAddr = 32'h8000_0008;
    localparam logic [31:0]        CtrlAddr   = 32'h8000_0000;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
    } state_t;
`endif

    logic [7:0]           mem_r [Depth];
    logic [DepthLog2-1:0] wr_ptr_r, rd_ptr_r;
    logic [DepthLog2:0]   count_r;
    logic                 overflow_r;
    state_t               state_r, state_n;
    logic [CntW-1:0]      cyc_r, cyc_n;
    logic [2:0]           bit_r, bit_n;
    logic [7:0]           shift_r, shift_n;
    logic                 sout_r, sout_n;
    logic                 pop_s, push_req_s, push_s, clear_s, full_s, empty_s, sym_end_s;
    logic [7:0]           head_s;
    logic [31:0]          count_ext_s;
    logic                 unused_ok_s;
`ifdef UART_TX_PARITY_EN
    logic                 par_r;
`endif

    assign full_s      = (count_r == DepthCnt);
    assign empty_s     = (count_r == '0);
    assign push_req_s  = (Addr == TxDataAddr) && IO_trans[0];
    assign push_s      = push_req_s && !full_s;
    assign clear_s     = (Addr == CtrlAddr) && IO_trans[0];
    assign head_s      = mem_r[rd_ptr_r];
    assign sym_end_s   = (cyc_r == CycLast);
    assign count_ext_s = 32'(count_r);
    assign unused_ok_s = ^{WData[31:8], IO_trans[3:1], count_ext_s[31:4]};

    assign Status    = {25'd0, count_ext_s[3:0], overflow_r, (empty_s && (state_r == IDLE)), !full_s};
    assign TxBusy    = (state_r != IDLE) || !empty_s;
    assign FPGA_Sout = sout_r;

    // FIFO storage; emptiness is tracked by pointers/count so the array needs no reset
    always_ff @(posedge Clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= WData[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            // a full-FIFO store and a clear never coincide: they decode different addresses
            if (push_req_s && full_s) overflow_r <= 1'b1;
            else if (clear_s)         overflow_r <= 1'b0;
        end
    end

    // Transmit FSM state, bit timing and the registered serial line
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            cyc_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            sout_r  <= 1'b1;
        end else begin
            state_r <= state_n;
            cyc_r   <= cyc_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            sout_r  <= sout_n;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the byte being sent, captured as it leaves the FIFO
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)   par_r <= 1'b0;
        else if (pop_s) par_r <= even_parity(head_s);
        else            par_r <= par_r;
    end
`endif

    // Next-state logic; sout_n is the line level belonging to the next state
    always_comb begin
        state_n = state_r;
        cyc_n   = cyc_r;
        bit_n   = bit_r;
        shift_n = shift_r;
        sout_n  = sout_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                sout_n = 1'b1;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_n = head_s;
                    cyc_n   = '0;
                    state_n = START;
                    sout_n  = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (sym_end_s) begin
                    cyc_n   = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                    sout_n  = shift_r[0];
                end else begin
                    cyc_n  = cyc_r + 1'b1;
                    sout_n = 1'b0;
                end
            end
            DATA: begin
                if (sym_end_s) begin
                    cyc_n = '0;
                    if (bit_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        sout_n  = par_r;
`else
                        state_n = STOP;
                        sout_n  = 1'b1;
`endif
                    end else begin
                        bit_n   = bit_r + 3'd1;
                        shift_n = {1'b0, shift_r[7:1]};
                        sout_n  = shift_r[1];
                    end
                end else begin
                    cyc_n  = cyc_r + 1'b1;
                    sout_n = shift_r[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (sym_end_s) begin
                    cyc_n   = '0;
                    state_n = STOP;
                    sout_n  = 1'b1;
                end else begin
                    cyc_n  = cyc_r + 1'b1;
                    sout_n = par_r;
                end
            end
`endif
            STOP: begin
                if (sym_end_s) begin
                    cyc_n = '0;
                    // chain straight into the next frame so back-to-back bytes have no gap
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_n = head_s;
                        state_n = START;
                        sout_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                        sout_n  = 1'b1;
                    end
                end else begin
                    cyc_n  = cyc_r + 1'b1;
                    sout_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cyc_n   = '0;
                bit_n   = 3'd0;
                sout_n  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a frame-position reference model is compared every cycle.
module tb_uart_tx_mmio;

    localparam int SE = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * SE;
`else
    localparam int FRAME = 10 * SE;
`endif
    localparam logic [31:0] TX   = 32'h8000_0008;
    localparam logic [31:0] CTRL = 32'h8000_0000;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WData = 32'h0;
    logic [3:0]  IO_trans = 4'h0;
    logic [31:0] Status;
    logic        FPGA_Sout;
    logic        TxBusy;

    int compared = 0;
    int mismatched = 0;

    // reference model: pending bytes, position inside the current frame (-1 = idle)
    logic [7:0] q[$];
    int         pos;
    logic [7:0] cur;
    logic       ovf;

    uart_tx_mmio #(.ClockFreq(100), .BaudRate(10), .DepthLog2(3)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Addr(Addr), .WData(WData),
        .IO_trans(IO_trans), .Status(Status), .FPGA_Sout(FPGA_Sout), .TxBusy(TxBusy)
    );

    always #5 Clock = ~Clock;

    function automatic void model_reset();
        q.delete();
        pos = -1;
        cur = 8'h00;
        ovf = 1'b0;
    endfunction

    function automatic void model_step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
        bit full_b = (q.size() >= 8);
        bit pop = 1'b0;
        if (pos < 0) begin
            if (q.size() > 0) pop = 1'b1;
        end else if (pos == FRAME - 1) begin
            if (q.size() > 0) pop = 1'b1;
            else pos = -1;
        end else begin
            pos++;
        end
        if (pop) begin
            cur = q.pop_front();
            pos = 0;
        end
        if (a == TX && t[0]) begin
            if (full_b) ovf = 1'b1;
            else q.push_back(d[7:0]);
        end
        if (a == CTRL && t[0]) ovf = 1'b0;
    endfunction

    function automatic logic exp_sout();
        int b;
        if (pos < 0) return 1'b1;
        b = pos / SE;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^cur;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s = 32'h0;
        s[0]   = (q.size() < 8);
        s[1]   = (q.size() == 0) && (pos < 0);
        s[2]   = ovf;
        s[6:3] = 4'(q.size());
        return s;
    endfunction

    task automatic check_all(input string tag);
        logic        es = exp_sout();
        logic [31:0] st = exp_status();
        logic        eb = (pos >= 0) || (q.size() != 0);
        compared++;
        assert (FPGA_Sout === es) else begin
            mismatched++;
            $error("FAIL %s sout t=%0t got %b exp %b", tag, $time, FPGA_Sout, es);
        end
        compared++;
        assert (Status === st) else begin
            mismatched++;
            $error("FAIL %s status t=%0t got %h exp %h", tag, $time, Status, st);
        end
        compared++;
        assert (TxBusy === eb) else begin
            mismatched++;
            $error("FAIL %s busy t=%0t got %b exp %b", tag, $time, TxBusy, eb);
        end
    endtask

    task automatic tick(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] t);
        Addr = a;
        WData = d;
        IO_trans = t;
        @(posedge Clock);
        model_step(a, d, t);
        #1;
        Addr = 32'h0;
        IO_trans = 4'h0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        int n;
        int r;
        model_reset();

        // reset state
        #12;
        check_val("reset_status", Status, 32'h3);
        check_val("reset_sout", 32'(FPGA_Sout), 32'h1);
        check_val("reset_busy", 32'(TxBusy), 32'h0);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        check_all("post_reset");

        // single byte A5
        tick("single", TX, 32'h0000_00A5, 4'b0001);
        check_val("single_status_push", Status, 32'h9);
        tick("single", 32'h0, 32'h0, 4'h0);
        check_val("single_status_frame", Status, 32'h1);
        check_val("single_start_bit", 32'(FPGA_Sout), 32'h0);
        idle("single", FRAME + 5);
        check_val("single_status_done", Status, 32'h3);

        // ignored stores
        tick("ignored", TX, 32'h0000_003C, 4'b0000);
        tick("ignored", 32'h8000_0004, 32'h0000_003C, 4'b0001);
        idle("ignored", 20);
        check_val("ignored_status", Status, 32'h3);

        // back-to-back frames, busy length
        n = 0;
        tick("b2b", TX, 32'h01, 4'b0001);
        if (TxBusy) n++;
        tick("b2b", TX, 32'h80, 4'b0001);
        if (TxBusy) n++;
        for (int i = 0; i < 600 && TxBusy; i++) begin
            tick("b2b", 32'h0, 32'h0, 4'h0);
            if (TxBusy) n++;
        end
        check_val("b2b_busy_cycles", 32'(n), 32'(1 + 2 * FRAME));

        // overflow
        for (int i = 0; i < 10; i++) tick("ovf", TX, 32'(i), 4'b0001);
        check_val("ovf_flag_set", 32'(Status[2]), 32'h1);
        check_val("ovf_count", 32'(Status[6:3]), 32'h8);
        tick("ovf_clear", CTRL, 32'h0, 4'b0001);
        check_val("ovf_flag_clear", 32'(Status[2]), 32'h0);
        for (int i = 0; i < 1200 && TxBusy; i++) tick("ovf_drain", 32'h0, 32'h0, 4'h0);
        check_val("ovf_drained", Status, 32'h3);

        // frame length of a single byte
        n = 0;
        tick("flen", TX, 32'h07, 4'b0001);
        if (TxBusy) n++;
        for (int i = 0; i < 300 && TxBusy; i++) begin
            tick("flen", 32'h0, 32'h0, 4'h0);
            if (TxBusy) n++;
        end
        check_val("frame_len", 32'(n), 32'(1 + FRAME));

        // reset mid-frame
        tick("midrst", TX, 32'h00, 4'b0001);
        idle("midrst", 34);
        #3;
        Reset_n = 1'b0;
        #1;
        check_val("midrst_sout", 32'(FPGA_Sout), 32'h1);
        check_val("midrst_status", Status, 32'h3);
        check_val("midrst_busy", 32'(TxBusy), 32'h0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        model_reset();
        idle("midrst_after", 150);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10)       tick("rnd", TX, 32'($urandom), {3'($urandom), 1'b1});
            else if (r < 13)  tick("rnd", TX, 32'($urandom), {3'($urandom), 1'b0});
            else if (r < 15)  tick("rnd", CTRL, 32'($urandom), 4'b0001);
            else if (r < 17)  tick("rnd", 32'h8000_0004, 32'($urandom), 4'b0001);
            else if (r == 99) begin
                for (int k = 0; k < 11; k++) tick("rnd_burst", TX, 32'($urandom), 4'b0001);
            end
            else              tick("rnd", 32'h0, 32'h0, 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
